// File: rtl/hack_ps2_keyboard.sv
// PS/2 set-2 receiver and Hack key decoder: scan_valid/frame_err one cycle after the stop-bit edge, kb one cycle later.
// No backpressure: the keyboard drives the pace and every frame is consumed as it arrives.
module hack_ps2_keyboard #(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] kb,
    output logic        scan_valid,
    output logic [7:0]  scan_code,
    output logic        frame_err
);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYCLES);
    localparam logic [IW-1:0] IDLE_ONE = IW'(1);

    logic [SYNC_STAGES-1:0] r_clk_sync, r_data_sync;
    logic                   r_clk_prev;
    logic [3:0]             r_bit_cnt;
    logic [9:0]             r_bits;
    logic [IW-1:0]          r_idle;
    logic                   r_scan_valid, r_frame_err;
    logic [7:0]             r_scan_code;
    logic                   r_brk, r_ext;
    logic [7:0]             r_key;

    logic       w_clk_s, w_data_s, w_edge, w_frame_ok, w_timeout;
    logic [7:0] w_code;

    assign w_clk_s   = r_clk_sync[SYNC_STAGES-1];
    assign w_data_s  = r_data_sync[SYNC_STAGES-1];
    assign w_edge    = r_clk_prev & ~w_clk_s;
    // r_bits[0] holds the start bit, r_bits[9] the parity bit; w_data_s is the stop bit.
    assign w_frame_ok = ~r_bits[0] & (^r_bits[9:1]) & w_data_s;
    assign w_timeout  = (r_bit_cnt != 4'd0) && (r_idle == IDLE_MAX);

    assign kb         = {8'h00, r_key};
    assign scan_valid = r_scan_valid;
    assign scan_code  = r_scan_code;
    assign frame_err  = r_frame_err;

    // Synchronisers reset to the idle-high line level so no false edge follows reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
            r_clk_prev  <= w_clk_s;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bit_cnt    <= 4'd0;
            r_bits       <= 10'd0;
            r_idle       <= '0;
            r_scan_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_scan_code  <= 8'h00;
        end else begin
            r_scan_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            if (w_edge) begin
                r_idle <= '0;
                if (r_bit_cnt == 4'd10) begin
                    r_bit_cnt <= 4'd0;
                    if (w_frame_ok) begin
                        r_scan_valid <= 1'b1;
                        r_scan_code  <= r_bits[8:1];
                    end else begin
                        r_frame_err  <= 1'b1;
                    end
                end else begin
                    r_bits    <= {w_data_s, r_bits[9:1]};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end else begin
                if (r_idle != IDLE_MAX)
                    r_idle <= r_idle + IDLE_ONE;
                if (w_timeout)
                    r_bit_cnt <= 4'd0;
            end
        end
    end

    always_comb begin
        w_code = 8'd0;
        if (r_ext) begin
            case (r_scan_code)
                8'h6B: w_code = 8'd130;  8'h75: w_code = 8'd131;  8'h74: w_code = 8'd132;
                8'h72: w_code = 8'd133;  8'h6C: w_code = 8'd134;  8'h69: w_code = 8'd135;
                8'h7D: w_code = 8'd136;  8'h7A: w_code = 8'd137;  8'h70: w_code = 8'd138;
                8'h71: w_code = 8'd139;  8'h5A: w_code = 8'd128;
                default: w_code = 8'd0;
            endcase
        end else begin
            case (r_scan_code)
                8'h1C: w_code = 8'd65;  8'h32: w_code = 8'd66;  8'h21: w_code = 8'd67;
                8'h23: w_code = 8'd68;  8'h24: w_code = 8'd69;  8'h2B: w_code = 8'd70;
                8'h34: w_code = 8'd71;  8'h33: w_code = 8'd72;  8'h43: w_code = 8'd73;
                8'h3B: w_code = 8'd74;  8'h42: w_code = 8'd75;  8'h4B: w_code = 8'd76;
                8'h3A: w_code = 8'd77;  8'h31: w_code = 8'd78;  8'h44: w_code = 8'd79;
                8'h4D: w_code = 8'd80;  8'h15: w_code = 8'd81;  8'h2D: w_code = 8'd82;
                8'h1B: w_code = 8'd83;  8'h2C: w_code = 8'd84;  8'h3C: w_code = 8'd85;
                8'h2A: w_code = 8'd86;  8'h1D: w_code = 8'd87;  8'h22: w_code = 8'd88;
                8'h35: w_code = 8'd89;  8'h1A: w_code = 8'd90;
                8'h45: w_code = 8'd48;  8'h16: w_code = 8'd49;  8'h1E: w_code = 8'd50;
                8'h26: w_code = 8'd51;  8'h25: w_code = 8'd52;  8'h2E: w_code = 8'd53;
                8'h36: w_code = 8'd54;  8'h3D: w_code = 8'd55;  8'h3E: w_code = 8'd56;
                8'h46: w_code = 8'd57;  8'h29: w_code = 8'd32;
                8'h41: w_code = 8'd44;  8'h49: w_code = 8'd46;  8'h4A: w_code = 8'd47;
                8'h4E: w_code = 8'd45;  8'h55: w_code = 8'd61;  8'h4C: w_code = 8'd59;
                8'h52: w_code = 8'd39;  8'h54: w_code = 8'd91;  8'h5B: w_code = 8'd93;
                8'h5D: w_code = 8'd92;  8'h0E: w_code = 8'd96;
                8'h5A: w_code = 8'd128; 8'h66: w_code = 8'd129; 8'h76: w_code = 8'd140;
                8'h05: w_code = 8'd141; 8'h06: w_code = 8'd142; 8'h04: w_code = 8'd143;
                8'h0C: w_code = 8'd144; 8'h03: w_code = 8'd145; 8'h0B: w_code = 8'd146;
                8'h83: w_code = 8'd147; 8'h0A: w_code = 8'd148; 8'h01: w_code = 8'd149;
                8'h09: w_code = 8'd150; 8'h78: w_code = 8'd151; 8'h07: w_code = 8'd152;
                default: w_code = 8'd0;
            endcase
        end
    end

    // Releasing a key other than the held one leaves kb alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_brk <= 1'b0;
            r_ext <= 1'b0;
            r_key <= 8'd0;
        end else if (r_scan_valid) begin
            if (r_scan_code == 8'hF0) begin
                r_brk <= 1'b1;
            end else if (r_scan_code == 8'hE0) begin
                r_ext <= 1'b1;
            end else begin
                if (!r_brk && (w_code != 8'd0))
                    r_key <= w_code;
                else if (r_brk && (w_code == r_key))
                    r_key <= 8'd0;
                r_brk <= 1'b0;
                r_ext <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_hack_ps2_keyboard.sv
// Randomised PS/2 frames checked every cycle against a table-driven key model.
module tb_hack_ps2_keyboard;
    localparam int TO = 300;
    localparam int H  = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [15:0] kb;
    logic        scan_valid;
    logic [7:0]  scan_code;
    logic        frame_err;

    hack_ps2_keyboard #(.TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .kb(kb), .scan_valid(scan_valid), .scan_code(scan_code), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct { bit err; logic [7:0] b; } exp_t;
    exp_t expq[$];

    int total = 0;
    int bad = 0;
    int norm_map[256];
    int ext_map[256];
    int norm_keys[$];
    int ext_keys[$];
    int m_kb = 0;
    int m_code = 0;
    bit m_brk = 0;
    bit m_ext = 0;
    int err_seen = 0;
    int err_sent = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic init_maps();
        logic [7:0] letters[26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,8'h42,8'h4B,8'h3A,
                                    8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
        logic [7:0] digits[10]  = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
        logic [7:0] fkeys[12]   = '{8'h05,8'h06,8'h04,8'h0C,8'h03,8'h0B,8'h83,8'h0A,8'h01,8'h09,8'h78,8'h07};
        logic [7:0] punct[11]   = '{8'h41,8'h49,8'h4A,8'h4E,8'h55,8'h4C,8'h52,8'h54,8'h5B,8'h5D,8'h0E};
        int         punct_c[11] = '{44,46,47,45,61,59,39,91,93,92,96};
        logic [7:0] ext[10]     = '{8'h6B,8'h75,8'h74,8'h72,8'h6C,8'h69,8'h7D,8'h7A,8'h70,8'h71};
        for (int i = 0; i < 256; i++) begin norm_map[i] = 0; ext_map[i] = 0; end
        for (int i = 0; i < 26; i++) norm_map[letters[i]] = 65 + i;
        for (int i = 0; i < 10; i++) norm_map[digits[i]] = 48 + i;
        for (int i = 0; i < 12; i++) norm_map[fkeys[i]] = 141 + i;
        for (int i = 0; i < 11; i++) norm_map[punct[i]] = punct_c[i];
        norm_map[8'h29] = 32; norm_map[8'h5A] = 128; norm_map[8'h66] = 129; norm_map[8'h76] = 140;
        for (int i = 0; i < 10; i++) ext_map[ext[i]] = 130 + i;
        ext_map[8'h5A] = 128;
        for (int i = 0; i < 256; i++) begin
            if (norm_map[i] != 0) norm_keys.push_back(i);
            if (ext_map[i] != 0) ext_keys.push_back(i);
        end
    endtask

    function automatic void model_byte(input logic [7:0] b);
        int c;
        if (b == 8'hF0) m_brk = 1;
        else if (b == 8'hE0) m_ext = 1;
        else begin
            c = m_ext ? ext_map[b] : norm_map[b];
            if (!m_brk && c != 0) m_kb = c;
            else if (m_brk && c == m_kb) m_kb = 0;
            m_brk = 0;
            m_ext = 0;
        end
    endfunction

    // Pulses are matched to the frames the driver sent; kb must follow the model one cycle later.
    always @(negedge clk) begin
        exp_t e;
        bit   dec;
        dec = 0;
        if (reset) begin
            m_kb = 0; m_code = 0; m_brk = 0; m_ext = 0;
            expq.delete();
            chk("rst_kb", int'(kb), 0);
            chk("rst_scan_valid", int'(scan_valid), 0);
            chk("rst_frame_err", int'(frame_err), 0);
            chk("rst_scan_code", int'(scan_code), 0);
        end else begin
            if (scan_valid || frame_err) begin
                if (expq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL pulse_unexpected scan_valid=%0b frame_err=%0b at %0t", scan_valid, frame_err, $time);
                end else begin
                    e = expq.pop_front();
                    chk("pulse_is_err", int'(frame_err), int'(e.err));
                    chk("pulse_is_valid", int'(scan_valid), int'(!e.err));
                    if (frame_err) err_seen++;
                    if (!e.err) begin m_code = int'(e.b); dec = 1; end
                end
            end
            chk("kb", int'(kb), m_kb);
            chk("scan_code", int'(scan_code), m_code);
            if (dec) model_byte(e.b);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_bits(input logic [10:0] f, input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            ps2_data = f[i];
            wait_cyc(H);
            ps2_clk = 1'b0;
            wait_cyc(H);
            ps2_clk = 1'b1;
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bpar, input bit bstart, input bit bstop);
        return {~bstop, (~^b) ^ bpar, b, bstart};
    endfunction

    task automatic send_frame(input logic [7:0] b, input bit bpar, input bit bstart, input bit bstop);
        exp_t e;
        e.err = bpar | bstart | bstop;
        e.b   = b;
        if (e.err) err_sent++;
        expq.push_back(e);
        send_bits(mk_frame(b, bpar, bstart, bstop), 0, 11);
        ps2_data = 1'b1;
        wait_cyc(12);
    endtask

    task automatic good(input logic [7:0] b);
        send_frame(b, 0, 0, 0);
    endtask

    task automatic expect_kb(input string name, input int v);
        chk({name, "_dut"}, int'(kb), v);
        chk({name, "_model"}, m_kb, v);
    endtask

    initial begin
        logic [10:0] f;
        int r;
        logic [7:0] b;
        init_maps();
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(5);
        expect_kb("after_reset", 0);

        good(8'h1C);                 expect_kb("make_A", 65);
        good(8'hF0); good(8'h1C);    expect_kb("break_A", 0);
        good(8'hE0); good(8'h75);    expect_kb("ext_up", 131);
        good(8'hE0); good(8'hF0); good(8'h75); expect_kb("ext_up_rel", 0);
        good(8'h75);                 expect_kb("plain_75_unmapped", 0);
        good(8'h1C); good(8'h5A);    expect_kb("newline", 128);
        good(8'hF0); good(8'h1C);    expect_kb("rel_noncurrent", 128);
        good(8'hF0); good(8'h5A);    expect_kb("rel_newline", 0);

        send_frame(8'h29, 1, 0, 0);  expect_kb("bad_parity", 0);
        chk("err_after_parity", err_seen, 1);
        good(8'h29);                 expect_kb("space", 32);
        send_frame(8'h1C, 0, 1, 0);  expect_kb("bad_start", 32);
        send_frame(8'h1C, 0, 0, 1);  expect_kb("bad_stop", 32);
        chk("err_after_start_stop", err_seen, 3);

        send_bits(mk_frame(8'h66, 0, 0, 0), 0, 4);
        ps2_data = 1'b1;
        wait_cyc(TO + 10);
        good(8'h66);                 expect_kb("after_timeout", 129);
        chk("err_after_timeout", err_seen, 3);

        // A gap just under the timeout must not break the frame.
        begin
            exp_t e;
            e.err = 0; e.b = 8'h1C;
            expq.push_back(e);
            f = mk_frame(8'h1C, 0, 0, 0);
            send_bits(f, 0, 5);
            wait_cyc(TO - 40);
            send_bits(f, 5, 11);
            ps2_data = 1'b1;
            wait_cyc(12);
        end
        expect_kb("near_timeout", 65);

        for (int i = 0; i < 90; i++) begin
            r = $urandom_range(0, 11);
            if (r < 2) b = 8'hF0;
            else if (r == 2) b = 8'hE0;
            else if (r == 3) b = 8'($urandom);
            else if (r == 4) b = 8'(ext_keys[$urandom_range(0, ext_keys.size() - 1)]);
            else b = 8'(norm_keys[$urandom_range(0, norm_keys.size() - 1)]);
            r = $urandom_range(0, 9);
            send_frame(b, r == 0, r == 1, r == 2);
        end

        good(8'hF0); good(8'h76);
        good(8'h76);                 expect_kb("esc", 140);
        send_bits(mk_frame(8'h05, 0, 0, 0), 0, 5);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset_kb", int'(kb), 0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        ps2_data = 1'b1;
        wait_cyc(5);
        good(8'h05);                 expect_kb("f1_after_reset", 141);

        wait_cyc(10);
        chk("pending_pulses", expq.size(), 0);
        chk("err_count", err_seen, err_sent);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
